// File: rtl/sign_compress_16.sv
// Iterative sign compression: scans a 16-bit word MSB-down to find its minimum
// signed width, then packs it into a target field, saturating on overflow.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// SCAN  | comparing r[idx] against the sign bit, one bit per cycle
// DONE  | result registered, done pulses; a new start is accepted here
module sign_compress_16 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        tgt_width,
    output logic              busy,
    output logic              done,
    output logic [4:0]        min_width,
    output logic [DATA_W-1:0] out_data,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] r;
    logic [4:0]        t;
    logic [3:0]        idx;

    logic [4:0]        t_eff;
    logic              differ;
    logic              last;
    logic [4:0]        w;
    logic              fits;
    logic [DATA_W-1:0] low_mask;
    logic [DATA_W-1:0] half;
    logic [DATA_W-1:0] packed_val;

    // Out-of-range target widths fall back to the full operand width.
    assign t_eff = (tgt_width == 5'd0 || tgt_width > 5'd16) ? 5'd16 : tgt_width;

    assign differ = (r[idx] != r[DATA_W-1]);
    assign last   = (idx == 4'd0);
    assign w      = differ ? ({1'b0, idx} + 5'd2) : 5'd1;
    assign fits   = (w <= t);

    // t is always 1..16 here, so both shift amounts stay within 0..15.
    assign low_mask = {DATA_W{1'b1}} >> (5'd16 - t);
    assign half     = {{(DATA_W-1){1'b0}}, 1'b1} << (t - 5'd1);

    always_comb begin
        packed_val = '0;
        if (fits) begin
            packed_val = r & low_mask;
        end else if (r[DATA_W-1]) begin
            packed_val = half;
        end else begin
            packed_val = half - {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            t         <= 5'd16;
            idx       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            min_width <= 5'd0;
            out_data  <= '0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        r     <= in_data;
                        t     <= t_eff;
                        idx   <= 4'd14;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (differ || last) begin
                        min_width <= w;
                        ovf       <= ~fits;
                        out_data  <= packed_val;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_compress_16.sv
// Self-checking bench for sign_compress_16: directed table, hand-written
// multi-cycle sequences, and randomized operands against a value-range model.
module tb_sign_compress_16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_data;
    logic [4:0]  tgt_width;
    logic        busy;
    logic        done;
    logic [4:0]  min_width;
    logic [15:0] out_data;
    logic        ovf;

    int vectors;
    int miscompares;

    sign_compress_16 #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .tgt_width (tgt_width),
        .busy      (busy),
        .done      (done),
        .min_width (min_width),
        .out_data  (out_data),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  tgt;
        int          w;
        int          ovf;
        int          out;
        int          lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Smallest w such that the value lies in -(2^(w-1)) .. 2^(w-1)-1.
    function automatic int ref_width(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        for (int w = 1; w <= 16; w++) begin
            if (v >= -(1 << (w - 1)) && v <= (1 << (w - 1)) - 1) return w;
        end
        return 16;
    endfunction

    function automatic int ref_pack(input logic [15:0] d, input int t, input int w);
        int v;
        v = int'($signed(d));
        if (w <= t) return v & ((1 << t) - 1);
        if (v >= 0) return (1 << (t - 1)) - 1;
        return 1 << (t - 1);
    endfunction

    task automatic start_op(input logic [15:0] d, input logic [4:0] tg);
        in_data   = d;
        tgt_width = tg;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle index (1 = first cycle after the accepting edge) in
    // which done is seen; -1 on timeout. Optionally pulses start at cycle pulse_at.
    task automatic wait_done(input int pulse_at, output int lat);
        int k;
        k   = 1;
        lat = -1;
        while (k <= 40) begin
            if (done) begin
                lat = k;
                break;
            end
            check("busy_while_scanning", int'(busy), 1);
            if (pulse_at != 0 && k == pulse_at) begin
                start     = 1'b1;
                in_data   = 16'h7FFF;
                tgt_width = 5'd16;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (lat > 0) check("busy_in_done_cycle", int'(busy), 0);
    endtask

    task automatic check_result(input string tag, input int lat, input int elat,
                                input int ew, input int eovf, input int eout);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_min_width"}, int'(min_width), ew);
        check({tag, "_ovf"}, int'(ovf), eovf);
        check({tag, "_out_data"}, int'(out_data), eout);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_min_width"}, int'(min_width), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
    endtask

    vec_t tbl[10];

    initial begin
        int lat;
        int teff;
        int ew;
        int nscan;
        int seen_done;
        logic [15:0] xs;
        logic [15:0] d;
        logic [4:0]  tg;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        in_data     = 16'h0;
        tgt_width   = 5'd0;

        tbl[0] = '{16'h0100, 5'd8,  10, 1, 'h007F, 8};
        tbl[1] = '{16'hFF80, 5'd8,  8,  0, 'h0080, 10};
        tbl[2] = '{16'h4000, 5'd0,  16, 0, 'h4000, 2};
        tbl[3] = '{16'hFFFF, 5'd1,  1,  0, 'h0001, 16};
        tbl[4] = '{16'h8000, 5'd4,  16, 1, 'h0008, 2};
        tbl[5] = '{16'h0001, 5'd16, 2,  0, 'h0001, 16};
        tbl[6] = '{16'h0000, 5'd20, 1,  0, 'h0000, 16};
        tbl[7] = '{16'h0005, 5'd1,  4,  1, 'h0000, 14};
        tbl[8] = '{16'hFFF0, 5'd1,  5,  1, 'h0001, 13};
        tbl[9] = '{16'h7FFF, 5'd15, 16, 1, 'h3FFF, 2};

        // Reset held two cycles, then idle with no start.
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_reset_outputs("idle_after_reset");
        end

        for (int i = 0; i < 10; i++) begin
            start_op(tbl[i].data, tbl[i].tgt);
            wait_done(0, lat);
            check_result($sformatf("table%0d", i), lat, tbl[i].lat,
                         tbl[i].w, tbl[i].ovf, tbl[i].out);
            @(negedge clk);
            check("done_single_pulse", int'(done), 0);
        end

        // Start while busy is ignored; then a start in the DONE cycle is accepted.
        start_op(16'h0000, 5'd16);
        wait_done(5, lat);
        check_result("ignored_start", lat, 16, 1, 0, 'h0000);
        start_op(16'h7FFF, 5'd16);
        wait_done(0, lat);
        check_result("back_to_back", lat, 2, 16, 0, 'h7FFF);

        // Reset in the middle of a scan aborts it.
        @(negedge clk);
        start_op(16'h0001, 5'd16);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_scan_reset");
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check("no_done_after_abort", seen_done, 0);
        start_op(16'h0001, 5'd16);
        wait_done(0, lat);
        check_result("after_abort", lat, 16, 2, 0, 'h0001);

        // Randomized operands spread across all widths.
        for (int i = 0; i < 150; i++) begin
            xs = 16'($urandom);
            d  = 16'($signed(xs) >>> $urandom_range(0, 15));
            tg = 5'($urandom_range(0, 31));
            teff  = (tg == 5'd0 || tg > 5'd16) ? 16 : int'(tg);
            ew    = ref_width(d);
            nscan = (ew >= 2) ? 17 - ew : 15;
            start_op(d, tg);
            wait_done(0, lat);
            check_result($sformatf("rand%0d", i), lat, nscan + 1, ew,
                         (ew > teff) ? 1 : 0, ref_pack(d, teff, ew));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sign_compress_16.md
# sign_compress_16

Iterative sign-compression unit: the narrowing counterpart to the datapath's sign-extension logic. It takes a 16-bit two's-complement word and scans it one bit per cycle to find the minimum signed width that holds the value. It then packs the value into a requested target field width, saturating and flagging overflow if the value does not fit. It sits beside the ALU/accumulator path and is used when a register value is written back into a narrow immediate or offset field.

## Interface
- DATA_W, 16, operand width; only 16 is supported and verified.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- in_data  in  16  two's-complement operand, sampled on the accepting edge.
- tgt_width  in  5  target field width, 1..16; 0 or values >16 are treated as 16; sampled with in_data.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- min_width  out  5  minimum signed width of the operand, 1..16.
- out_data  out  16  packed result in bits [t-1:0], where t is the effective target width; bits above t are 0.
- ovf  out  1  1 when min_width > t; out_data then holds the saturated value.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE/DONE with start=1:
  - Latch in_data into r and the effective target width into t.
  - Load idx=14 and go to SCAN.
- IDLE/DONE with start=0: go to (or stay in) IDLE.
- SCAN, one compare per cycle:
  - If r[idx] != r[15]: w = idx+2; go to DONE.
  - Else if idx = 0: w = 1; go to DONE.
  - Else: idx decrements; stay in SCAN.
- Entering DONE registers min_width=w and ovf=(w>t).
- out_data when ovf=0: r masked to its low t bits.
- out_data when ovf=1, r[15]=0 (positive saturation): bits [t-2:0]=1, bit t-1=0.
- out_data when ovf=1, r[15]=1 (negative saturation): bit t-1=1, bits [t-2:0]=0.
- t=1: representable range is -1..0. Positive saturation gives 0x0000; negative saturation gives 0x0001.
- start while busy=1 is ignored; no queueing.
- Outputs hold their values until the next DONE or a reset.

## Timing
- Reset values: state=IDLE, busy=0, done=0, min_width=0, out_data=0x0000, ovf=0.
- Reset during SCAN aborts the operation: no done pulse, outputs return to reset values.
- Let the start be accepted on edge T.
  - busy=1 from T+1 through the last SCAN cycle.
  - Number of SCAN cycles = 17-w for w>=2, and 15 for w=1.
  - done=1 in cycle T+1+(SCAN cycles); busy=0 in that cycle.
- Best-case latency (w=16) is 2 cycles; worst case (w=1, or w=2 which needs 15 compares) is 16 cycles.
- Back-to-back operation: start asserted during DONE is accepted on that edge, giving a new SCAN in the next cycle.
- done never stays high for two consecutive cycles.
- busy and done are never high together.

## Test plan
- Reset, then idle: with rst held 2 cycles and then released with no start, all outputs stay at their reset values and busy/done stay 0.
- Overflow: start with in_data=0x0100, tgt_width=8 -> w=10, done at T+8, min_width=10, ovf=1, out_data=0x007F.
- Fitting negative value: start with in_data=0xFF80, tgt_width=8 -> done at T+10, min_width=8, ovf=0, out_data=0x0080.
- Extremes:
  - in_data=0x4000, tgt_width=0 -> done at T+2, min_width=16, ovf=0, out_data=0x4000.
  - in_data=0xFFFF, tgt_width=1 -> done at T+16, min_width=1, ovf=0, out_data=0x0001.
  - in_data=0x8000, tgt_width=4 -> min_width=16, ovf=1, out_data=0x0008.
- Start while busy, then back-to-back:
  - Start 0x0000 (tgt 16), pulse start again at T+5 with 0x7FFF -> second request ignored; done at T+16 with min_width=1, out_data=0x0000.
  - Start 0x7FFF in the DONE cycle -> accepted; next done follows 2 cycles later with min_width=16.
- Reset mid-scan: assert rst at T+4 of a 0x0001 scan -> no done pulse, outputs return to 0; a fresh start afterwards completes normally with min_width=2.
